// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_pkg
// Purpose  : Types and helpers shared by the serial_port transmitter and the
//            serial_rx receiver. Holds the common four-state frame sequence
//            and the baud divisor calculation.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package serial_pkg;

  // Frame phases shared by the TX and RX state machines.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } serial_state_e;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_port_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_port_if
// Purpose  : Byte-level bus between the memory controller's serial-port
//            window and the UART.
// Signals  : tx_data/tx_start   controller -> UART, byte to send + strobe
//            write_ready        UART -> controller, transmitter idle
//            rx_data            UART -> controller, received byte
//            read_ready         UART -> controller, unread byte / interrupt
//            read_ack           controller -> UART, clears read flags
//            rx_overrun         UART -> controller, sticky overrun flag
// Modports : master (controller side), slave (UART side)
// Revision : 1.0  initial release
// ============================================================================
interface serial_port_if;

  logic [7:0] tx_data;
  logic       tx_start;
  logic       write_ready;
  logic [7:0] rx_data;
  logic       read_ready;
  logic       read_ack;
  logic       rx_overrun;

  modport master (
    output tx_data, tx_start, read_ack,
    input  write_ready, rx_data, read_ready, rx_overrun
  );

  modport slave (
    input  tx_data, tx_start, read_ack,
    output write_ready, rx_data, read_ready, rx_overrun
  );

endinterface
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx
// Purpose  : 8N1 receiver. Synchronises the asynchronous line, samples each
//            bit at its centre, checks the stop bit and keeps the last good
//            byte in a holding register.
// Ports    : clk     in   system clock
//            rst     in   synchronous active-high reset
//            i_rxd   in   raw serial input (asynchronous)
//            o_data  out  holding register, last good byte
//            o_done  out  high in the cycle a good byte is loaded
// Revision : 1.0  initial release
// ============================================================================
module serial_rx
  import serial_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_done
);

  localparam int             TW     = $clog2(DIV);
  localparam logic [TW-1:0]  C_FULL = TW'(DIV - 1);
  localparam logic [TW-1:0]  C_HALF = TW'(DIV / 2);
  localparam logic [TW-1:0]  C_ONE  = TW'(1);

  logic          r_sync1;
  logic          r_sync2;
  serial_state_e r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_ferr;
  logic [7:0]    r_data;

  logic w_rxd;
  logic w_tick;
  logic w_done;

  assign w_rxd  = r_sync2;
  assign w_tick = (r_timer == '0);
  // A good byte completes when the stop sample is high and no framing
  // error was already seen for this frame.
  assign w_done = (r_state == STOP) && w_tick && w_rxd && !r_ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= IDLE;
      r_timer <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_ferr  <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;

      case (r_state)
        IDLE: begin
          r_ferr <= 1'b0;
          if (!w_rxd) begin
            r_state <= START;
            r_timer <= C_HALF;
          end
        end

        START: begin
          if (w_tick) begin
            if (w_rxd) begin
              r_state <= IDLE;              // glitch, not a start bit
            end else begin
              r_state <= DATA;
              r_timer <= C_FULL;
              r_idx   <= 3'd0;
            end
          end else begin
            r_timer <= r_timer - C_ONE;
          end
        end

        DATA: begin
          if (w_tick) begin
            r_shift <= {w_rxd, r_shift[7:1]};
            r_timer <= C_FULL;
            if (r_idx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_timer <= r_timer - C_ONE;
          end
        end

        STOP: begin
          // Timer parks at zero; the state then waits for the line to go
          // high. A low first stop sample marks the frame as bad so the
          // later high does not deliver it.
          if (!w_tick) begin
            r_timer <= r_timer - C_ONE;
          end else if (w_rxd) begin
            if (!r_ferr) begin
              r_data <= r_shift;
            end
            r_state <= IDLE;
          end else begin
            r_ferr <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_data = r_data;
  assign o_done = w_done;

endmodule
`default_nettype wire

// File: rtl/serial_port.sv
`default_nettype none
// ============================================================================
// Module   : serial_port
// Purpose  : Byte-wide 8N1 UART behind the memory controller's serial-port
//            window. Contains the transmitter and the read status flags;
//            reception is delegated to serial_rx.
// Ports    : clk       in   system clock
//            rst       in   synchronous active-high reset
//            bus       --   serial_port_if.slave (tx byte/strobe, status,
//                           rx byte, read_ack, overrun)
//            uart_rxd  in   serial input (asynchronous)
//            uart_txd  out  serial output, idles high
// Revision : 1.0  initial release
// ============================================================================
module serial_port
  import serial_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DIV    = baud_div(CLK_HZ, BAUD)
) (
  input  logic                clk,
  input  logic                rst,
  serial_port_if.slave        bus,
  input  logic                uart_rxd,
  output logic                uart_txd
);

  localparam int             TW     = $clog2(DIV);
  localparam logic [TW-1:0]  C_FULL = TW'(DIV - 1);
  localparam logic [TW-1:0]  C_ONE  = TW'(1);

  // ---------------------------------------------------------------- TX ---
  serial_state_e r_tx_state;
  logic [TW-1:0] r_tx_timer;
  logic [2:0]    r_tx_idx;
  logic [7:0]    r_tx_shift;
  logic          r_txd;
  logic          w_tx_tick;

  assign w_tx_tick = (r_tx_timer == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= IDLE;
      r_tx_timer <= '0;
      r_tx_idx   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        IDLE: begin
          if (bus.tx_start) begin
            r_tx_shift <= bus.tx_data;
            r_tx_idx   <= 3'd0;
            r_tx_timer <= C_FULL;
            r_txd      <= 1'b0;
            r_tx_state <= START;
          end
        end

        START: begin
          if (w_tx_tick) begin
            r_txd      <= r_tx_shift[0];
            r_tx_timer <= C_FULL;
            r_tx_state <= DATA;
          end else begin
            r_tx_timer <= r_tx_timer - C_ONE;
          end
        end

        DATA: begin
          // Shift register moves right once per bit so bit 0 is always the
          // one on the line and bit 1 is the next to go out.
          if (w_tx_tick) begin
            r_tx_timer <= C_FULL;
            if (r_tx_idx == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= STOP;
            end else begin
              r_tx_idx   <= r_tx_idx + 3'd1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_txd      <= r_tx_shift[1];
            end
          end else begin
            r_tx_timer <= r_tx_timer - C_ONE;
          end
        end

        STOP: begin
          if (w_tx_tick) begin
            r_tx_state <= IDLE;
          end else begin
            r_tx_timer <= r_tx_timer - C_ONE;
          end
        end

        default: r_tx_state <= IDLE;
      endcase
    end
  end

  assign uart_txd        = r_txd;
  assign bus.write_ready = (r_tx_state == IDLE);

  // ---------------------------------------------------------------- RX ---
  logic [7:0] w_rx_data;
  logic       w_rx_done;

  serial_rx #(
    .DIV (DIV)
  ) u_rx (
    .clk    (clk),
    .rst    (rst),
    .i_rxd  (uart_rxd),
    .o_data (w_rx_data),
    .o_done (w_rx_done)
  );

  // ------------------------------------------------------------- flags ---
  logic r_read_ready;
  logic r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_ready <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_rx_done) begin
      // An arriving byte beats a simultaneous acknowledge.
      r_read_ready <= 1'b1;
      r_overrun    <= r_read_ready | (r_overrun & ~bus.read_ack);
    end else if (bus.read_ack) begin
      r_read_ready <= 1'b0;
      r_overrun    <= 1'b0;
    end
  end

  assign bus.read_ready = r_read_ready;
  assign bus.rx_overrun = r_overrun;
  assign bus.rx_data    = w_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_serial_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_port
// Purpose  : Self-checking bench for serial_port at DIV = 16. Expected line
//            waveforms and status flags come from a frame-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_port;

  localparam int DIV    = 16;
  localparam int FRAME  = 10 * DIV;
  // Negedge index (from the negedge that drives the start bit low) at which
  // read_ready is first visible: 2 sync + DIV/2 + 9*DIV + 1, plus one for
  // the first posedge that sees the line.
  localparam int DONE_I = DIV / 2 + 9 * DIV + 4;

  logic clk;
  logic rst;
  logic uart_rxd;
  logic uart_txd;

  serial_port_if u_if ();

  serial_port #(
    .CLK_HZ (16),
    .BAUD   (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (u_if),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Reference status of the receive side.
  logic       m_ready;
  logic       m_ovr;
  logic [7:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_rx(input string tag);
    chk({tag, "_ready"}, u_if.read_ready, m_ready);
    chk({tag, "_ovr"},   u_if.rx_overrun, m_ovr);
    chk({tag, "_data"},  u_if.rx_data,    m_data);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Caller has already put tx_start high for the cycle before edge 1.
  // Optionally fires a second strobe at cycle busy_cyc, which must be ignored.
  task automatic tx_run(input logic [7:0] b, input int busy_cyc, input logic [7:0] busy_b);
    int   slot;
    logic exp_line;
    for (int c = 1; c <= FRAME + 1; c++) begin
      @(negedge clk);
      if (c == busy_cyc) begin
        u_if.tx_start = 1'b1;
        u_if.tx_data  = busy_b;
      end else begin
        u_if.tx_start = 1'b0;
      end
      slot = (c - 1) / DIV;
      if (slot == 0)      exp_line = 1'b0;
      else if (slot <= 8) exp_line = b[slot-1];
      else                exp_line = 1'b1;
      chk("tx_line", uart_txd, exp_line);
      chk("tx_wr",   u_if.write_ready, (c > FRAME) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic tx_begin(input logic [7:0] b);
    @(negedge clk);
    u_if.tx_data  = b;
    u_if.tx_start = 1'b1;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit, input logic ack_done);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      uart_rxd = frame[i / DIV];
      if (i == DONE_I - 1) begin
        chk_rx("rx_pre");
        if (ack_done) u_if.read_ack = 1'b1;
      end
      if (i == DONE_I) begin
        u_if.read_ack = 1'b0;
        if (stop_bit) begin
          m_ovr   = m_ready | (m_ovr & ~ack_done);
          m_ready = 1'b1;
          m_data  = b;
        end
        chk_rx("rx_post");
      end
    end
    @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    u_if.read_ack = 1'b1;
    @(negedge clk);
    u_if.read_ack = 1'b0;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    chk_rx("ack");
  endtask

  initial begin
    logic [7:0] b;
    logic [9:0] frame;
    n_cmp = 0;
    n_err = 0;
    rst           = 1'b1;
    uart_rxd      = 1'b1;
    u_if.tx_data  = 8'h00;
    u_if.tx_start = 1'b0;
    u_if.read_ack = 1'b0;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    m_data  = 8'h00;

    // Reset state
    idle(3);
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_wr",  u_if.write_ready, 1'b1);
    chk_rx("rst");
    rst = 1'b0;
    idle(2);

    // TX frame shape, with an ignored strobe mid-frame
    tx_begin(8'hA5);
    tx_run(8'hA5, 50, 8'h3C);

    // Back-to-back random frames, each strobe in the cycle write_ready returns
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      u_if.tx_data  = b;
      u_if.tx_start = 1'b1;
      tx_run(b, (k == 1) ? int'($urandom_range(2, FRAME - 1)) : 0, 8'($urandom));
    end
    idle(4);

    // Reset in the middle of a TX frame
    tx_begin(8'($urandom));
    idle(40);
    u_if.tx_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_txd", uart_txd, 1'b1);
    chk("mid_rst_wr",  u_if.write_ready, 1'b1);
    idle(DIV);
    chk("post_rst_txd", uart_txd, 1'b1);

    // RX good byte, then ack
    rx_send(8'h5A, 1'b1, 1'b0);
    idle(DIV);
    ack_pulse();

    // Overrun: two frames without ack
    rx_send(8'h11, 1'b1, 1'b0);
    idle(DIV);
    rx_send(8'h22, 1'b1, 1'b0);
    idle(DIV);
    chk("ovr_flag", u_if.rx_overrun, 1'b1);
    ack_pulse();

    // Ack held in the completing cycle: the byte wins
    rx_send(8'h33, 1'b1, 1'b1);
    idle(DIV);
    ack_pulse();

    // Short low glitch rejected
    @(negedge clk);
    uart_rxd = 1'b0;
    idle(5);
    uart_rxd = 1'b1;
    idle(3 * DIV);
    chk_rx("glitch");

    // Framing error discarded, then a good frame
    rx_send(8'h7E, 1'b0, 1'b0);
    idle(DIV);
    chk_rx("ferr");
    rx_send(8'h81, 1'b1, 1'b0);
    idle(DIV);

    // Random frames with random acknowledges
    for (int k = 0; k < 4; k++) begin
      rx_send(8'($urandom), 1'b1, 1'b0);
      idle(int'($urandom_range(DIV, 2 * DIV)));
      if ($urandom_range(0, 1) == 1) ack_pulse();
    end

    // Reset in the middle of an RX frame; bits after the reset are all high
    b = {7'h7F, 1'($urandom)};
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      uart_rxd = frame[i / DIV];
      if (i == 40) rst = 1'b1;
      if (i == 41) begin
        rst = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_data  = 8'h00;
        chk_rx("rx_rst");
      end
    end
    uart_rxd = 1'b1;
    idle(2 * DIV);
    chk_rx("rx_rst_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
